// File: rtl/dsp_opt_mode_default__mac_pipe_if.sv
// Operand/result bundle for the default-mode DSP multiply-accumulate pipe.
// Handshake: valid-only, no ready; a sample is taken on every clk edge with in_valid=1, and out_valid marks the single cycle a new result is presented.
interface dsp_opt_mode_default__mac_pipe_if #(
   parameter int A_WIDTH   = 9,
   parameter int B_WIDTH   = 9,
   parameter int ACC_WIDTH = 24
);
   logic                 in_valid;
   logic [A_WIDTH-1:0]   a;
   logic [B_WIDTH-1:0]   b;
   logic                 is_signed;
   logic                 acc_clr;
   logic                 acc_en;
   logic                 out_valid;
   logic [ACC_WIDTH-1:0] result;
   logic                 overflow;

   modport master (
      output in_valid, a, b, is_signed, acc_clr, acc_en,
      input  out_valid, result, overflow
   );

   modport slave (
      input  in_valid, a, b, is_signed, acc_clr, acc_en,
      output out_valid, result, overflow
   );
endinterface

// File: rtl/dsp_opt_mode_default__mac_pipe.sv
// Three-stage registered multiply-accumulate: operand capture, product, accumulate.
// All extension and padding bits come from the tile's const0 tie-off rather than literal zeros.
module dsp_opt_mode_default__mac_pipe #(
   parameter int A_WIDTH   = 9,
   parameter int B_WIDTH   = 9,
   parameter int ACC_WIDTH = 24
) (
   input  logic clk,
   input  logic reset_n,
   input  logic const0,
   dsp_opt_mode_default__mac_pipe_if.slave bus
);
   localparam int P_WIDTH = A_WIDTH + B_WIDTH;

   // S1: operand capture
   logic               v1;
   logic [A_WIDTH-1:0] a1;
   logic [B_WIDTH-1:0] b1;
   logic               sgn1, clr1, en1;

   // S2: product
   logic               v2;
   logic [P_WIDTH-1:0] prod2;
   logic               sgn2, clr2, en2;
   logic               ext_a, ext_b;
   logic [P_WIDTH-1:0] a_ext, b_ext, prod_full;

   // S3: accumulate
   logic                 out_valid_q;
   logic [ACC_WIDTH-1:0] result_q;
   logic                 overflow_q;
   logic                 ext_p;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH:0]   sum_full;
   logic                 ovf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         sgn1 <= 1'b0;
         clr1 <= 1'b0;
         en1  <= 1'b0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            a1   <= bus.a;
            b1   <= bus.b;
            sgn1 <= bus.is_signed;
            clr1 <= bus.acc_clr;
            en1  <= bus.acc_en;
         end
      end
   end

   // Fill with the extension bit, then overlay the operand; works for any width split.
   always_comb begin
      ext_a = sgn1 ? a1[A_WIDTH-1] : const0;
      ext_b = sgn1 ? b1[B_WIDTH-1] : const0;
      a_ext = {P_WIDTH{ext_a}};
      a_ext[A_WIDTH-1:0] = a1;
      b_ext = {P_WIDTH{ext_b}};
      b_ext[B_WIDTH-1:0] = b1;
      prod_full = a_ext * b_ext;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2    <= 1'b0;
         prod2 <= '0;
         sgn2  <= 1'b0;
         clr2  <= 1'b0;
         en2   <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            prod2 <= prod_full;
            sgn2  <= sgn1;
            clr2  <= clr1;
            en2   <= en1;
         end
      end
   end

   // Signed overflow: like-signed addends whose sum flips sign; unsigned: carry out.
   always_comb begin
      ext_p    = sgn2 ? prod2[P_WIDTH-1] : const0;
      prod_ext = {ACC_WIDTH{ext_p}};
      prod_ext[P_WIDTH-1:0] = prod2;
      sum_full = {const0, result_q} + {const0, prod_ext};
      if (sgn2)
         ovf = (result_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (sum_full[ACC_WIDTH-1] != result_q[ACC_WIDTH-1]);
      else
         ovf = sum_full[ACC_WIDTH];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         out_valid_q <= v2;
         if (v2) begin
            if (!en2) begin
               result_q <= prod_ext;
            end else if (clr2) begin
               result_q   <= prod_ext;
               overflow_q <= 1'b0;
            end else begin
               result_q   <= sum_full[ACC_WIDTH-1:0];
               overflow_q <= overflow_q | ovf;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;

   // A non-zero tie-off corrupts every extension bit.
   const0_is_zero: assert property (@(posedge clk) disable iff (!reset_n) const0 == 1'b0);

endmodule

// File: tb/tb_dsp_opt_mode_default__mac_pipe.sv
// Directed bench for the default-mode MAC pipe with a queue-based scoreboard.
module tb_dsp_opt_mode_default__mac_pipe;
   localparam int AW = 9;
   localparam int BW = 9;
   localparam int CW = 24;

   logic clk;
   logic reset_n;
   logic const0;

   dsp_opt_mode_default__mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) bus ();

   dsp_opt_mode_default__mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .const0  (const0),
      .bus     (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: {overflow, result}
   logic [CW:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        stim_done = 1'b0;

   // driver tasks
   task automatic send(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                       input logic sg, input logic cl, input logic en,
                       input logic push, input logic [CW:0] exp);
      bus.in_valid  = 1'b1;
      bus.a         = av;
      bus.b         = bv;
      bus.is_signed = sg;
      bus.acc_clr   = cl;
      bus.acc_en    = en;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // idle cycles carry junk operands and acc_clr=1, all of which must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid  = 1'b0;
         bus.acc_clr   = 1'b1;
         bus.acc_en    = 1'b1;
         bus.a         = AW'($urandom_range(0, (1 << AW) - 1));
         bus.b         = BW'($urandom_range(0, (1 << BW) - 1));
         @(posedge clk);
         #1;
      end
      bus.acc_clr = 1'b0;
   endtask

   // monitor: pop on out_valid, check hold otherwise, finish after drain
   logic [CW:0] last_out;
   logic [CW:0] act;
   logic [CW:0] e;
   int          drain_cnt = 0;

   always @(negedge clk) begin
      act = {bus.overflow, bus.result};
      if (!reset_n) begin
         last_out = '0;
      end else if (bus.out_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: out_valid=1 result=%h overflow=%b, required no output",
                     bus.result, bus.overflow);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL result: got result=%h overflow=%b, required result=%h overflow=%b",
                        act[CW-1:0], act[CW], e[CW-1:0], e[CW]);
            end
         end
         last_out = act;
      end else begin
         n_tests++;
         if (act !== last_out) begin
            n_fail++;
            $display("FAIL hold: got result=%h overflow=%b, required result=%h overflow=%b",
                     act[CW-1:0], act[CW], last_out[CW-1:0], last_out[CW]);
         end
      end
      if (stim_done) begin
         drain_cnt++;
         if (exp_q.size() == 0 || drain_cnt > 20) begin
            n_tests++;
            if (exp_q.size() != 0) begin
               n_fail++;
               $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   end

   // stimulus
   longint s;
   initial begin
      reset_n       = 1'b0;
      const0        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.is_signed = 1'b0;
      bus.acc_clr   = 1'b0;
      bus.acc_en    = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(2);

      // reset mid-flight: both samples must vanish
      send(9'd5, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      send(9'd5, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      idle(5);

      // unsigned pass-through, 511*511
      send(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b1, {1'b0, 24'h03FC01});
      idle(4);

      // signed pass-through: -256*-1, then -256*-256
      send(9'h100, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 24'h000100});
      send(9'h100, 9'h100, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 24'h010000});
      idle(4);

      // back-to-back signed accumulate: 6, 26, 19
      send(9'd2, 9'd3, 1'b1, 1'b1, 1'b1, 1'b1, {1'b0, 24'd6});
      send(9'd4, 9'd5, 1'b1, 1'b0, 1'b1, 1'b1, {1'b0, 24'd26});
      send(9'h1FF, 9'd7, 1'b1, 1'b0, 1'b1, 1'b1, {1'b0, 24'd19});
      idle(4);

      // same sequence with bubbles
      send(9'd2, 9'd3, 1'b1, 1'b1, 1'b1, 1'b1, {1'b0, 24'd6});
      idle(2);
      send(9'd4, 9'd5, 1'b1, 1'b0, 1'b1, 1'b1, {1'b0, 24'd26});
      idle(2);
      send(9'h1FF, 9'd7, 1'b1, 1'b0, 1'b1, 1'b1, {1'b0, 24'd19});
      idle(5);

      // unsigned carry-out: 65 * 261121 crosses 2^24
      send(9'h1FF, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 24'd261121});
      for (int k = 2; k <= 65; k++) begin
         s = 64'd261121 * k;
         send(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b1,
              {(s >= 64'd16777216), s[CW-1:0]});
      end
      idle(4);

      // signed overflow: 130 * 65025 exceeds 2^23-1
      send(9'd255, 9'd255, 1'b1, 1'b1, 1'b1, 1'b1, {1'b0, 24'd65025});
      for (int k = 2; k <= 130; k++) begin
         s = 64'd65025 * k;
         send(9'd255, 9'd255, 1'b1, 1'b0, 1'b1, 1'b1,
              {(s > 64'd8388607), s[CW-1:0]});
      end
      // pass-through keeps the sticky flag, a clear sample drops it
      send(9'd2, 9'd2, 1'b1, 1'b0, 1'b0, 1'b1, {1'b1, 24'd4});
      send(9'd1, 9'd1, 1'b1, 1'b1, 1'b1, 1'b1, {1'b0, 24'd1});
      idle(5);

      stim_done = 1'b1;
      repeat (200) @(posedge clk);
      $display("FAIL watchdog: monitor never finished, required finish within 20 cycles");
      $fatal(1, "watchdog expired");
   end
endmodule
